// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: forwarding-select generator and load-use stall detector.
// The unit keeps shadow copies of in-flight destinations (EX, MEM, WB and
// optionally a retired stage) and compares them against the decode-stage
// sources. The resulting ALU operand mux selects are registered as the
// instruction enters EX.
// Select encoding: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 retired (WB+1).
// Optional feature: define FWD_RETIRE_BYPASS_EN to enable the retired-stage
// bypass (select 11). Without it, the WB and retired shadow stages are
// omitted because nothing beyond MEM can influence the selects.
module fwd_sel_unit #(
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall_req
);

   typedef enum logic {IDLE, STALL} state_t;

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EX  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;
`ifdef FWD_RETIRE_BYPASS_EN
   localparam logic [1:0] SEL_RET = 2'b11;
`endif

   state_t            state_q, state_d;

   // The load flag only matters while the load sits in EX, so it is not
   // carried further down the shadow pipe.
   logic              ex_valid_q, ex_valid_d;
   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   logic              ex_reg_write_q, ex_reg_write_d;
   logic              ex_mem_read_q, ex_mem_read_d;

   logic              mem_valid_q, mem_valid_d;
   logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
   logic              mem_reg_write_q, mem_reg_write_d;

`ifdef FWD_RETIRE_BYPASS_EN
   logic              wb_valid_q, wb_valid_d;
   logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
   logic              wb_reg_write_q, wb_reg_write_d;

   logic              ret_valid_q, ret_valid_d;
   logic [REG_AW-1:0] ret_rd_q, ret_rd_d;
   logic              ret_reg_write_q, ret_reg_write_d;
`endif

   logic [1:0]        fwd_a_q, fwd_a_d;
   logic [1:0]        fwd_b_q, fwd_b_d;

   logic              hazard;
   logic              enter_ex;

   // A stage supplies a value for src only if it really writes a non-zero rd.
   function automatic logic stage_hit(
      input logic              valid,
      input logic              reg_write,
      input logic [REG_AW-1:0] rd,
      input logic [REG_AW-1:0] src
   );
      stage_hit = valid & reg_write & (rd != '0) & (rd == src);
   endfunction

   // Load-use detection, stall request and decision whether decode enters EX.
   always_comb begin
      hazard = id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) &
               ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));
      stall_req = rst_n & (state_q == IDLE) & hazard & ~flush;
      enter_ex  = id_valid & ~flush & ~stall_req;
   end

   // Next-state for the stall FSM: a stall lasts at most one cycle and flush
   // always returns the machine to IDLE.
   always_comb begin
      state_d = IDLE;
      if (state_q == IDLE && hazard && !flush) begin
         state_d = STALL;
      end
   end

   // Shadow pipe advance; a squashed or stalled decode becomes an EX bubble.
   always_comb begin
      ex_valid_d      = enter_ex;
      ex_rd_d         = id_rd;
      ex_reg_write_d  = id_reg_write;
      ex_mem_read_d   = id_mem_read;
      mem_valid_d     = ex_valid_q;
      mem_rd_d        = ex_rd_q;
      mem_reg_write_d = ex_reg_write_q;
`ifdef FWD_RETIRE_BYPASS_EN
      wb_valid_d      = mem_valid_q;
      wb_rd_d         = mem_rd_q;
      wb_reg_write_d  = mem_reg_write_q;
      ret_valid_d     = wb_valid_q;
      ret_rd_d        = wb_rd_q;
      ret_reg_write_d = wb_reg_write_q;
`endif
   end

   // Operand selects, checked oldest first so the newest producer overrides.
   always_comb begin
      fwd_a_d = SEL_RF;
      fwd_b_d = SEL_RF;
      if (enter_ex) begin
`ifdef FWD_RETIRE_BYPASS_EN
         if (stage_hit(wb_valid_q, wb_reg_write_q, wb_rd_q, id_rs1)) fwd_a_d = SEL_RET;
         if (stage_hit(wb_valid_q, wb_reg_write_q, wb_rd_q, id_rs2)) fwd_b_d = SEL_RET;
`endif
         if (stage_hit(mem_valid_q, mem_reg_write_q, mem_rd_q, id_rs1)) fwd_a_d = SEL_MEM;
         if (stage_hit(mem_valid_q, mem_reg_write_q, mem_rd_q, id_rs2)) fwd_b_d = SEL_MEM;
         if (stage_hit(ex_valid_q, ex_reg_write_q, ex_rd_q, id_rs1)) fwd_a_d = SEL_EX;
         if (stage_hit(ex_valid_q, ex_reg_write_q, ex_rd_q, id_rs2)) fwd_b_d = SEL_EX;
      end
   end

   // All state, including the FSM, updates here with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         ex_valid_q      <= 1'b0;
         ex_rd_q         <= '0;
         ex_reg_write_q  <= 1'b0;
         ex_mem_read_q   <= 1'b0;
         mem_valid_q     <= 1'b0;
         mem_rd_q        <= '0;
         mem_reg_write_q <= 1'b0;
`ifdef FWD_RETIRE_BYPASS_EN
         wb_valid_q      <= 1'b0;
         wb_rd_q         <= '0;
         wb_reg_write_q  <= 1'b0;
         ret_valid_q     <= 1'b0;
         ret_rd_q        <= '0;
         ret_reg_write_q <= 1'b0;
`endif
         fwd_a_q         <= SEL_RF;
         fwd_b_q         <= SEL_RF;
      end else begin
         state_q         <= state_d;
         ex_valid_q      <= ex_valid_d;
         ex_rd_q         <= ex_rd_d;
         ex_reg_write_q  <= ex_reg_write_d;
         ex_mem_read_q   <= ex_mem_read_d;
         mem_valid_q     <= mem_valid_d;
         mem_rd_q        <= mem_rd_d;
         mem_reg_write_q <= mem_reg_write_d;
`ifdef FWD_RETIRE_BYPASS_EN
         wb_valid_q      <= wb_valid_d;
         wb_rd_q         <= wb_rd_d;
         wb_reg_write_q  <= wb_reg_write_d;
         ret_valid_q     <= ret_valid_d;
         ret_rd_q        <= ret_rd_d;
         ret_reg_write_q <= ret_reg_write_d;
`endif
         fwd_a_q         <= fwd_a_d;
         fwd_b_q         <= fwd_b_d;
      end
   end

   assign fwd_a_sel = fwd_a_q;
   assign fwd_b_sel = fwd_b_q;

endmodule

// File: tb/tb_fwd_sel_unit.sv
// tb_fwd_sel_unit: directed vector table for the forwarding / load-use
// scenarios followed by random traffic against an age-based reference model.
module tb_fwd_sel_unit;

   localparam int REG_AW = 5;
`ifdef FWD_RETIRE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic              rst_n;
      logic              valid;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              rw;
      logic              mr;
      logic              fl;
      logic              exp_stall;
      logic [1:0]        exp_a;
      logic [1:0]        exp_b;
   } vec_t;

   logic              clk;
   logic              rst_n;
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
   logic              id_reg_write, id_mem_read, flush;
   logic [1:0]        fwd_a_sel, fwd_b_sel;
   logic              stall_req;

   int errors = 0;
   int checks = 0;

   fwd_sel_unit #(.REG_AW(REG_AW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .flush(flush), .fwd_a_sel(fwd_a_sel),
      .fwd_b_sel(fwd_b_sel), .stall_req(stall_req)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: what entered EX over the last three cycles (0 = newest)
   logic              hv[3];
   logic [REG_AW-1:0] hrd[3];
   logic              hrw[3];
   logic              hml[3];
   logic              m_stalled;

   function automatic vec_t mk(
      input logic r, input logic v, input int s1, input int s2, input int d,
      input logic w, input logic m, input logic f,
      input logic es, input logic [1:0] ea, input logic [1:0] eb);
      vec_t t;
      t.rst_n = r; t.valid = v; t.rs1 = REG_AW'(s1); t.rs2 = REG_AW'(s2);
      t.rd = REG_AW'(d); t.rw = w; t.mr = m; t.fl = f;
      t.exp_stall = es; t.exp_a = ea; t.exp_b = eb;
      return t;
   endfunction

   function automatic logic [1:0] model_pick(input logic [REG_AW-1:0] src);
      int depth;
      depth = BYP ? 3 : 2;
      if (src == 0) return 2'd0;
      for (int age = 0; age < depth; age++) begin
         if (hv[age] && hrw[age] && hrd[age] == src) return 2'(age + 1);
      end
      return 2'd0;
   endfunction

   function automatic vec_t model_expect(input vec_t v);
      vec_t t;
      logic hz, enter;
      t = v;
      if (!v.rst_n) begin
         t.exp_stall = 1'b0; t.exp_a = 2'd0; t.exp_b = 2'd0;
      end else begin
         hz = v.valid && hv[0] && hml[0] && hrd[0] != 0 &&
              (hrd[0] == v.rs1 || hrd[0] == v.rs2);
         t.exp_stall = hz && !m_stalled && !v.fl;
         enter = v.valid && !v.fl && !t.exp_stall;
         t.exp_a = enter ? model_pick(v.rs1) : 2'd0;
         t.exp_b = enter ? model_pick(v.rs2) : 2'd0;
      end
      return t;
   endfunction

   task automatic model_advance(input vec_t t);
      if (!t.rst_n) begin
         for (int i = 0; i < 3; i++) hv[i] = 1'b0;
         m_stalled = 1'b0;
      end else begin
         for (int i = 2; i > 0; i--) begin
            hv[i] = hv[i-1]; hrd[i] = hrd[i-1]; hrw[i] = hrw[i-1]; hml[i] = hml[i-1];
         end
         hv[0]  = t.valid && !t.fl && !t.exp_stall;
         hrd[0] = t.rd; hrw[0] = t.rw; hml[0] = t.mr;
         m_stalled = t.exp_stall;
      end
   endtask

   task automatic checkOutput(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   // Drive one decode cycle: stall is checked mid-cycle, selects just after the edge.
   task automatic applyStimulus(input vec_t t, input int idx, input bit use_model);
      rst_n = t.rst_n; id_valid = t.valid; id_rs1 = t.rs1; id_rs2 = t.rs2;
      id_rd = t.rd; id_reg_write = t.rw; id_mem_read = t.mr; flush = t.fl;
      @(negedge clk);
      checkOutput("stall_req", idx, int'(stall_req), int'(t.exp_stall));
      @(posedge clk);
      if (use_model) model_advance(t);
      #1;
      checkOutput("fwd_a_sel", idx, int'(fwd_a_sel), int'(t.exp_a));
      checkOutput("fwd_b_sel", idx, int'(fwd_b_sel), int'(t.exp_b));
   endtask

   vec_t tbl[32];

   initial begin
      vec_t cur, prev;
      logic [1:0] r3;
      r3 = BYP ? 2'd3 : 2'd0;

      rst_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
      @(posedge clk); #1;

      //            rst v  rs1 rs2 rd rw mr fl  stall a     b
      tbl[0]  = mk(0, 1,  5,  5,  5, 1, 0, 0,  0, 2'd0, 2'd0);
      tbl[1]  = mk(0, 1,  5,  5,  5, 1, 1, 0,  0, 2'd0, 2'd0);
      tbl[2]  = mk(1, 1,  5,  5,  6, 1, 0, 0,  0, 2'd0, 2'd0);
      tbl[3]  = mk(1, 1,  1,  2,  5, 1, 0, 0,  0, 2'd0, 2'd0);
      tbl[4]  = mk(1, 1,  5,  5,  6, 1, 0, 0,  0, 2'd1, 2'd1);
      tbl[5]  = mk(1, 1,  1,  2,  5, 1, 0, 0,  0, 2'd0, 2'd0);
      tbl[6]  = mk(1, 1,  0,  0,  0, 1, 0, 0,  0, 2'd0, 2'd0);
      tbl[7]  = mk(1, 1,  1,  5,  7, 1, 0, 0,  0, 2'd0, 2'd2);
      tbl[8]  = mk(1, 1,  3,  4,  5, 1, 0, 0,  0, 2'd0, 2'd0);
      tbl[9]  = mk(1, 1,  0,  0,  5, 1, 0, 0,  0, 2'd0, 2'd0);
      tbl[10] = mk(1, 1,  1,  5,  7, 1, 0, 0,  0, 2'd0, 2'd1);
      tbl[11] = mk(1, 1,  1,  0,  8, 1, 1, 0,  0, 2'd0, 2'd0);
      tbl[12] = mk(1, 1,  8,  2,  9, 1, 0, 0,  1, 2'd0, 2'd0);
      tbl[13] = mk(1, 1,  8,  2,  9, 1, 0, 0,  0, 2'd2, 2'd0);
      tbl[14] = mk(1, 1,  1,  2,  0, 1, 0, 0,  0, 2'd0, 2'd0);
      tbl[15] = mk(1, 1,  0,  0, 10, 1, 0, 0,  0, 2'd0, 2'd0);
      tbl[16] = mk(1, 1,  1,  0,  0, 1, 1, 0,  0, 2'd0, 2'd0);
      tbl[17] = mk(1, 1,  0,  0, 11, 1, 0, 0,  0, 2'd0, 2'd0);
      tbl[18] = mk(1, 1,  1,  1,  4, 1, 0, 0,  0, 2'd0, 2'd0);
      tbl[19] = mk(1, 1,  2,  0,  8, 1, 1, 0,  0, 2'd0, 2'd0);
      tbl[20] = mk(1, 1,  8,  4,  9, 1, 0, 1,  0, 2'd0, 2'd0);
      tbl[21] = mk(1, 1,  4,  3, 12, 1, 0, 0,  0, r3,   2'd0);
      tbl[22] = mk(1, 1,  8,  8, 13, 1, 0, 0,  0, r3,   r3);
      tbl[23] = mk(1, 1,  1,  0, 14, 1, 1, 0,  0, 2'd0, 2'd0);
      tbl[24] = mk(1, 1, 14,  0, 15, 1, 1, 0,  1, 2'd0, 2'd0);
      tbl[25] = mk(1, 1, 14,  0, 15, 1, 1, 0,  0, 2'd2, 2'd0);
      tbl[26] = mk(1, 1, 15, 15, 16, 1, 0, 0,  1, 2'd0, 2'd0);
      tbl[27] = mk(1, 1, 15, 15, 16, 1, 0, 0,  0, 2'd2, 2'd2);
      tbl[28] = mk(1, 1,  1,  0,  8, 1, 1, 0,  0, 2'd0, 2'd0);
      tbl[29] = mk(1, 1,  8,  8,  9, 1, 0, 0,  1, 2'd0, 2'd0);
      tbl[30] = mk(0, 1,  8,  8,  9, 1, 0, 0,  0, 2'd0, 2'd0);
      tbl[31] = mk(1, 1,  8,  8,  9, 1, 0, 0,  0, 2'd0, 2'd0);

      $display("[TB] directed vectors");
      for (int i = 0; i < 32; i++) applyStimulus(tbl[i], i, 1'b0);

      $display("[TB] random traffic");
      prev = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      cur = prev;
      applyStimulus(model_expect(cur), 1000, 1'b1);
      prev.exp_stall = 1'b0;
      for (int n = 0; n < 600; n++) begin
         if (prev.exp_stall) begin
            cur = prev;
         end else begin
            cur.valid = ($urandom_range(0, 9) != 0);
            cur.rs1   = REG_AW'($urandom_range(0, 5));
            cur.rs2   = REG_AW'($urandom_range(0, 5));
            cur.rd    = REG_AW'($urandom_range(0, 5));
            cur.rw    = ($urandom_range(0, 4) != 0);
            cur.mr    = ($urandom_range(0, 2) == 0);
         end
         cur.fl    = ($urandom_range(0, 11) == 0);
         cur.rst_n = ($urandom_range(0, 49) != 0);
         cur = model_expect(cur);
         applyStimulus(cur, 2000 + n, 1'b1);
         prev = cur;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
